// File: rtl/axis_chk.sv
// axis_chk: AXI-stream sink and checker for LFSR packet traffic.
// Every accepted beat is compared against a local reference LFSR that
// free-runs in lock step with the far-end source. The checker also verifies
// where 'last' falls in each packet, counts packets and bad beats, and raises
// 'done' after NPKT packets.
// The stream interface is flattened into lfsr_in_* ports.
// Supported ranges: DATAW <= 64 and LAT in 0..255.

module axis_chk #(
  parameter int          N     = 16,
  parameter int          DATAW = 64,
  parameter logic [63:0] SEED  = 64'hFEDCBA9876543210,
  parameter int          LAT   = 0,
  parameter logic        BP    = 1'b0,
  parameter int          NPKT  = 0
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic [DATAW-1:0] lfsr_in_data,
  input  logic             lfsr_in_vld,
  input  logic             lfsr_in_last,
  output logic             lfsr_in_rdy,
  output logic [31:0]      pkt_cnt,
  output logic [15:0]      err_cnt,
  output logic             data_err,
  output logic             last_err,
  output logic             done
);

  localparam int                 CntBitW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntBitW-1:0] LastBeat = CntBitW'(N - 1);
  localparam logic [7:0]         LatCnt   = 8'(LAT);
  localparam logic [31:0]        LastPkt  = 32'(NPKT - 1);
  localparam logic [7:0]         BpSeed   = 8'hA5;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         wait_cnt;
  logic [CntBitW-1:0] beat_cnt;
  logic [63:0]        ref_q;
  logic [7:0]         bp_q;

  logic               accept;
  logic               last_beat;
  logic               data_bad;
  logic               last_bad;
  logic [7:0]         bp_nxt;

  // Reference generator: x^64 + x^63 + x^61 + x^60 + 1, shifting left with
  // the feedback bit entering at bit 0. It must match the source's LFSR.
  function automatic logic [63:0] ref_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // Backpressure generator: x^8 + x^6 + x^5 + x^4 + 1, same shift direction.
  function automatic logic [7:0] bp_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Beat classification. rdy is only ever high in RUN, so the handshake
  // alone qualifies a beat; the state term keeps that explicit.
  assign accept    = (state == ST_RUN) && lfsr_in_vld && lfsr_in_rdy;
  assign last_beat = (beat_cnt == LastBeat);
  assign data_bad  = (lfsr_in_data != ref_q[DATAW-1:0]);
  assign last_bad  = (lfsr_in_last != last_beat);
  assign bp_nxt    = bp_step(bp_q);

  // Checker FSM: sequences WAIT/RUN/DONE and owns every registered output.
  //
  // WAIT holds the reference at SEED for LAT+1 cycles, which is the time the
  // source's first beat needs to cross the link. That first beat (SEED) is
  // not accepted, because rdy is low in WAIT. The reference therefore steps
  // on the edge that leaves WAIT, so it lines up with the beat that arrives
  // in the first RUN cycle.
  //
  // rdy is registered. Each cycle it is loaded with the value the
  // backpressure LFSR will hold next cycle, so in RUN it always equals bit 0
  // of the current bp_q.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state       <= ST_WAIT;
      wait_cnt    <= 8'd0;
      beat_cnt    <= '0;
      ref_q       <= SEED;
      bp_q        <= BpSeed;
      lfsr_in_rdy <= 1'b0;
      pkt_cnt     <= 32'd0;
      err_cnt     <= 16'd0;
      data_err    <= 1'b0;
      last_err    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == LatCnt) begin
            state       <= ST_RUN;
            ref_q       <= ref_step(ref_q);
            lfsr_in_rdy <= BP ? bp_q[0] : 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_RUN: begin
          ref_q       <= ref_step(ref_q);
          bp_q        <= bp_nxt;
          lfsr_in_rdy <= BP ? bp_nxt[0] : 1'b1;
          if (accept) begin
            if (data_bad) begin
              data_err <= 1'b1;
            end
            if (last_bad) begin
              last_err <= 1'b1;
            end
            if ((data_bad || last_bad) && (err_cnt != 16'hFFFF)) begin
              err_cnt <= err_cnt + 16'd1;
            end
            // The beat counter follows the accepted-beat count alone. A
            // stray or missing 'last' is reported but never used to resync.
            if (last_beat) begin
              beat_cnt <= '0;
              pkt_cnt  <= pkt_cnt + 32'd1;
              if ((NPKT != 0) && (pkt_cnt == LastPkt)) begin
                state       <= ST_DONE;
                done        <= 1'b1;
                lfsr_in_rdy <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + CntBitW'(1);
            end
          end
        end

        ST_DONE: begin
          ref_q       <= ref_step(ref_q);
          lfsr_in_rdy <= 1'b0;
          done        <= 1'b1;
        end

        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_chk.sv
// tb_axis_chk: directed bench for axis_chk. It uses three checker instances:
//   a: N=16, LAT=0, BP=0, NPKT=4 (clean run, data fault, last fault, async reset)
//   b: N=16, LAT=3, BP=1, NPKT=0 (3-stage link, modelled backpressure, 100 packets)
//   c: N=1,  LAT=0, BP=0, NPKT=0 (constant bad data until err_cnt saturates)

module tb_axis_chk;

  localparam logic [63:0] SEED = 64'hFEDCBA9876543210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a
  logic        a_rst, a_vld, a_last, a_rdy, a_data_err, a_last_err, a_done;
  logic [63:0] a_data;
  logic [31:0] a_pkt;
  logic [15:0] a_err;

  axis_chk #(.N(16), .DATAW(64), .SEED(SEED), .LAT(0), .BP(1'b0), .NPKT(4)) dut_a (
    .clk(clk), .a_rst(a_rst), .lfsr_in_data(a_data), .lfsr_in_vld(a_vld),
    .lfsr_in_last(a_last), .lfsr_in_rdy(a_rdy), .pkt_cnt(a_pkt), .err_cnt(a_err),
    .data_err(a_data_err), .last_err(a_last_err), .done(a_done)
  );

  // Instance b: data crosses three bench register stages before the checker
  logic        b_rst, b_vld, b_last, b_rdy, b_data_err, b_last_err, b_done;
  logic [63:0] b_src, b_p1, b_p2, b_p3;
  logic [31:0] b_pkt;
  logic [15:0] b_err;

  always @(posedge clk) begin
    b_p1 <= b_src;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end

  axis_chk #(.N(16), .DATAW(64), .SEED(SEED), .LAT(3), .BP(1'b1), .NPKT(0)) dut_b (
    .clk(clk), .a_rst(b_rst), .lfsr_in_data(b_p3), .lfsr_in_vld(b_vld),
    .lfsr_in_last(b_last), .lfsr_in_rdy(b_rdy), .pkt_cnt(b_pkt), .err_cnt(b_err),
    .data_err(b_data_err), .last_err(b_last_err), .done(b_done)
  );

  // Instance c: counts clock edges since its reset release
  logic        c_rst, c_vld, c_last, c_rdy, c_data_err, c_last_err, c_done;
  logic [63:0] c_data;
  logic [31:0] c_pkt;
  logic [15:0] c_err;
  int          c_edges = 0;

  always @(posedge clk) begin
    if (!c_rst) c_edges <= c_edges + 1;
  end

  axis_chk #(.N(1), .DATAW(64), .SEED(SEED), .LAT(0), .BP(1'b0), .NPKT(0)) dut_c (
    .clk(clk), .a_rst(c_rst), .lfsr_in_data(c_data), .lfsr_in_vld(c_vld),
    .lfsr_in_last(c_last), .lfsr_in_rdy(c_rdy), .pkt_cnt(c_pkt), .err_cnt(c_err),
    .data_err(c_data_err), .last_err(c_last_err), .done(c_done)
  );

  // Source LFSR (x^64+x^63+x^61+x^60+1, feedback into bit 0)
  function automatic logic [63:0] src_step(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  // Expected backpressure LFSR (x^8+x^6+x^5+x^4+1)
  function automatic logic [7:0] bp_model_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Instance a: a continuous source that steps every cycle from reset
  // release. The checker's first RUN cycle is cycle 1, so beat b is presented
  // in cycle b+1.
  task automatic applyStimulus(input string name, input int bad_beat, input bit swap_last,
                               input int abort_cycle, input int exp_err,
                               input bit exp_data_err, input bit exp_last_err);
    logic [63:0] src;
    int b;
    a_rst = 1'b1;
    a_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    src = SEED;
    for (int c = 0; c < 70; c++) begin
      b = c - 1;
      a_vld  = 1'b1;
      a_data = src;
      if (b == bad_beat) a_data[0] = ~a_data[0];
      a_last = (b >= 0) && (b % 16 == 15);
      if (swap_last && b == 7)  a_last = 1'b1;
      if (swap_last && b == 15) a_last = 1'b0;
      #1;
      if (c == 0)  checkOutput({name, "_rdy_in_wait"}, a_rdy, 0);
      if (c == 1)  checkOutput({name, "_rdy_in_run"}, a_rdy, 1);
      if (c == 16) checkOutput({name, "_pkt_before_first"}, a_pkt, 0);
      if (c == 17) checkOutput({name, "_pkt_after_first"}, a_pkt, 1);
      if (c == 64) begin
        checkOutput({name, "_pkt_before_final"}, a_pkt, 3);
        checkOutput({name, "_done_before_final"}, a_done, 0);
      end
      if (c == abort_cycle) begin
        checkOutput({name, "_pkt_before_abort"}, a_pkt, 2);
        checkOutput({name, "_rdy_before_abort"}, a_rdy, 1);
        #1;
        a_rst = 1'b1;
        #1;
        checkOutput({name, "_rdy_async_rst"}, a_rdy, 0);
        checkOutput({name, "_pkt_async_rst"}, a_pkt, 0);
        checkOutput({name, "_done_async_rst"}, a_done, 0);
        return;
      end
      @(posedge clk);
      #1;
      src = src_step(src);
    end
    checkOutput({name, "_pkt"}, a_pkt, 4);
    checkOutput({name, "_err"}, a_err, exp_err);
    checkOutput({name, "_data_err"}, a_data_err, exp_data_err);
    checkOutput({name, "_last_err"}, a_last_err, exp_last_err);
    checkOutput({name, "_done"}, a_done, 1);
    checkOutput({name, "_rdy_after_done"}, a_rdy, 0);
  endtask

  // Instance b: rdy is predicted from the 8-bit backpressure model, and
  // 'last' is driven from the predicted count of accepted beats.
  task automatic run_bp_traffic();
    logic [7:0] bp_model;
    logic       exp_rdy;
    int         acc;
    int         rdy_miss;
    bit         saw_lo;
    bit         saw_hi;
    b_rst = 1'b1;
    b_vld = 1'b0;
    b_last = 1'b0;
    b_src = SEED;
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    bp_model = 8'hA5;
    acc = 0;
    rdy_miss = 0;
    saw_lo = 1'b0;
    saw_hi = 1'b0;
    for (int c = 0; c < 8000 && acc < 1600; c++) begin
      exp_rdy = (c >= 4) ? bp_model[0] : 1'b0;
      b_vld  = 1'b1;
      b_last = (acc % 16 == 15);
      #1;
      if (b_rdy !== exp_rdy) rdy_miss++;
      if (c >= 4) begin
        if (b_rdy === 1'b1) saw_hi = 1'b1;
        if (b_rdy === 1'b0) saw_lo = 1'b1;
      end
      if (exp_rdy) acc++;
      if (c >= 4) bp_model = bp_model_step(bp_model);
      @(posedge clk);
      #1;
      b_src = src_step(b_src);
    end
    b_vld = 1'b0;
    checkOutput("b_beats_within_budget", acc, 1600);
    checkOutput("b_rdy_model_misses", rdy_miss, 0);
    checkOutput("b_rdy_toggles", saw_lo && saw_hi, 1);
    checkOutput("b_pkt", b_pkt, 100);
    checkOutput("b_err", b_err, 0);
    checkOutput("b_data_err", b_data_err, 0);
    checkOutput("b_last_err", b_last_err, 0);
    checkOutput("b_done_never", b_done, 0);
  endtask

  // Directed sequence
  initial begin
    a_rst = 1'b1; a_vld = 1'b0; a_last = 1'b0; a_data = '0;
    b_rst = 1'b1; b_vld = 1'b0; b_last = 1'b0; b_src = SEED;
    c_rst = 1'b1; c_vld = 1'b1; c_last = 1'b1; c_data = '0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("a_reset_rdy", a_rdy, 0);
    checkOutput("a_reset_pkt", a_pkt, 0);
    checkOutput("a_reset_err", a_err, 0);
    checkOutput("a_reset_data_err", a_data_err, 0);
    checkOutput("a_reset_last_err", a_last_err, 0);
    checkOutput("a_reset_done", a_done, 0);

    // Instance c: all-zero data never matches the reference; last=1 is correct for N=1
    c_rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("c_err_early", c_err, 9);
    checkOutput("c_pkt_early", c_pkt, 9);
    checkOutput("c_data_err_early", c_data_err, 1);
    checkOutput("c_last_err_n1", c_last_err, 0);

    applyStimulus("clean", -5, 1'b0, -1, 0, 1'b0, 1'b0);
    applyStimulus("bad_data", 21, 1'b0, -1, 1, 1'b1, 1'b0);
    applyStimulus("bad_last", -5, 1'b1, -1, 2, 1'b0, 1'b1);
    applyStimulus("abort", -5, 1'b0, 42, 0, 1'b0, 1'b0);
    applyStimulus("after_abort", -5, 1'b0, -1, 0, 1'b0, 1'b0);

    run_bp_traffic();

    for (int i = 0; i < 70000 && c_edges < 65600; i++) @(posedge clk);
    #1;
    checkOutput("c_edge_budget", c_edges >= 65600, 1);
    checkOutput("c_err_saturated", c_err, 16'hFFFF);
    checkOutput("c_data_err_sticky", c_data_err, 1);
    checkOutput("c_last_err_final", c_last_err, 0);
    checkOutput("c_pkt_count", c_pkt, c_edges - 1);
    checkOutput("c_done_never", c_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
